// File: rtl/shift_sequencer_pkg.sv
// Shared definitions for the multi-cycle shift unit: widths, op and state encodings.
package shift_defs;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned NUM_STAGES = 5;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRA = 2'b01,
        OP_SRL = 2'b10,
        OP_ROR = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_t;

endpackage

// File: rtl/shift_stage.sv
// Single selectable power-of-two shift stage shared by all sequencer steps.
module shift_stage
    import shift_defs::*;
(
    input  logic [DATA_W-1:0]     value,
    input  logic [NUM_STAGES-1:0] amount,
    input  op_t                   op,
    output logic [DATA_W-1:0]     result
);

    logic [5:0] n;

    always_comb begin
        n = '0;
        case (amount)
            5'b00001: n = 6'd1;
            5'b00010: n = 6'd2;
            5'b00100: n = 6'd4;
            5'b01000: n = 6'd8;
            5'b10000: n = 6'd16;
            default:  n = 6'd0;
        endcase
    end

    always_comb begin
        result = value;
        case (op)
            OP_SLL:  result = value << n;
            OP_SRL:  result = value >> n;
            OP_SRA:  result = $unsigned($signed(value) >>> n);
            // A zero amount makes the left term shift by 32, leaving value intact.
            OP_ROR:  result = (value >> n) | (value << (6'd32 - n));
            default: result = value;
        endcase
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle 32-bit shifter: one power-of-two stage per clock, MSB stage first,
// with a start/ready handshake; a new start always aborts and restarts.
module shift_sequencer
    import shift_defs::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              ctrl_start,
    input  logic [1:0]        ctrl_op,
    input  logic [4:0]        ctrl_shamt,
    input  logic [DATA_W-1:0] data_operandA,
    output logic [DATA_W-1:0] data_result,
    output logic              data_resultRDY,
    output logic              busy
);

    state_t                state_q, state_d;
    logic [2:0]            k_q, k_d;
    logic [DATA_W-1:0]     acc_q, acc_d;
    op_t                   op_q, op_d;
    logic [4:0]            shamt_q, shamt_d;
    logic [DATA_W-1:0]     result_d;
    logic [NUM_STAGES-1:0] amount;
    logic [DATA_W-1:0]     stage_out;
    logic [DATA_W-1:0]     stage_acc;

    assign amount = 5'b10000 >> k_q;

    shift_stage u_stage (
        .value  (acc_q),
        .amount (amount),
        .op     (op_q),
        .result (stage_out)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            k_q         <= '0;
            acc_q       <= '0;
            op_q        <= OP_SLL;
            shamt_q     <= '0;
            data_result <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            acc_q       <= acc_d;
            op_q        <= op_d;
            shamt_q     <= shamt_d;
            data_result <= result_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        k_d            = k_q;
        acc_d          = acc_q;
        op_d           = op_q;
        shamt_d        = shamt_q;
        result_d       = data_result;
        data_resultRDY = (state_q == ST_DONE);
        busy           = (state_q == ST_SHIFT);
        // Stage k is applied only when its shamt bit (MSB first) is set.
        stage_acc      = (|(shamt_q & amount)) ? stage_out : acc_q;

        if (ctrl_start) begin
            state_d = ST_SHIFT;
            k_d     = '0;
            acc_d   = data_operandA;
            op_d    = op_t'(ctrl_op);
            shamt_d = ctrl_shamt;
        end else begin
            case (state_q)
                ST_SHIFT: begin
                    acc_d = stage_acc;
                    if (k_q == 3'(NUM_STAGES - 1)) begin
                        result_d = stage_acc;
                        k_d      = '0;
                        state_d  = ST_DONE;
                    end else begin
                        k_d = k_q + 3'd1;
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed self-checking bench for shift_sequencer: results, latency, busy/RDY timing,
// restart, back-to-back and asynchronous reset.
module tb_shift_sequencer;

    logic        clock;
    logic        reset_n;
    logic        ctrl_start;
    logic [1:0]  ctrl_op;
    logic [4:0]  ctrl_shamt;
    logic [31:0] data_operandA;
    logic [31:0] data_result;
    logic        data_resultRDY;
    logic        busy;

    int vectors;
    int miscompares;
    logic [31:0] last_result;

    localparam logic [1:0] SLL = 2'b00;
    localparam logic [1:0] SRA = 2'b01;
    localparam logic [1:0] SRL = 2'b10;
    localparam logic [1:0] ROR = 2'b11;

    shift_sequencer dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .ctrl_start     (ctrl_start),
        .ctrl_op        (ctrl_op),
        .ctrl_shamt     (ctrl_shamt),
        .data_operandA  (data_operandA),
        .data_result    (data_result),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drives a start, returns #1 after the sampling edge t.
    task automatic do_start(input logic [1:0] op, input logic [4:0] sh, input logic [31:0] a);
        ctrl_start    = 1'b1;
        ctrl_op       = op;
        ctrl_shamt    = sh;
        data_operandA = a;
        @(posedge clock); #1;
        ctrl_start    = 1'b0;
        ctrl_op       = $urandom_range(3, 0);
        ctrl_shamt    = 5'($urandom);
        data_operandA = $urandom;
    endtask

    // Called #1 after edge t; returns #1 after edge t+5 (in the RDY cycle).
    task automatic wait_result(input string tag, input logic [31:0] exp, input logic [31:0] old);
        for (int c = 0; c < 5; c++) begin
            if (c > 0) begin
                @(posedge clock); #1;
            end
            chk({tag, " busy"}, busy, 1'b1);
            chk({tag, " rdy_early"}, data_resultRDY, 1'b0);
            chk({tag, " held"}, data_result, old);
        end
        @(posedge clock); #1;
        chk({tag, " rdy"}, data_resultRDY, 1'b1);
        chk({tag, " busy_rdy"}, busy, 1'b0);
        chk({tag, " result"}, data_result, exp);
        last_result = exp;
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [4:0] sh,
                          input logic [31:0] a, input logic [31:0] exp);
        do_start(op, sh, a);
        wait_result(tag, exp, last_result);
        @(posedge clock); #1;
        chk({tag, " rdy_off"}, data_resultRDY, 1'b0);
        chk({tag, " idle"}, busy, 1'b0);
        chk({tag, " hold"}, data_result, exp);
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        last_result   = 32'h0;
        reset_n       = 1'b0;
        ctrl_start    = 1'b0;
        ctrl_op       = 2'b00;
        ctrl_shamt    = 5'd0;
        data_operandA = 32'h0;
        @(posedge clock); @(posedge clock); #1;
        chk("reset result", data_result, 32'h0);
        chk("reset rdy", data_resultRDY, 1'b0);
        chk("reset busy", busy, 1'b0);
        reset_n = 1'b1;
        @(posedge clock); #1;
        chk("post-reset rdy", data_resultRDY, 1'b0);

        run_op("sra16",  SRA, 5'd16, 32'h80000000, 32'hFFFF8000);
        run_op("sll31",  SLL, 5'd31, 32'h00000001, 32'h80000000);
        run_op("srl4",   SRL, 5'd4,  32'hF0000000, 32'h0F000000);
        run_op("ror1",   ROR, 5'd1,  32'h00000001, 32'h80000000);
        run_op("ror16",  ROR, 5'd16, 32'h12345678, 32'h56781234);
        run_op("ror4",   ROR, 5'd4,  32'h12345678, 32'h81234567);
        run_op("sra31",  SRA, 5'd31, 32'h80000000, 32'hFFFFFFFF);
        run_op("sra3p",  SRA, 5'd3,  32'h7FFFFFFF, 32'h0FFFFFFF);
        run_op("sll0",   SLL, 5'd0,  32'hDEADBEEF, 32'hDEADBEEF);
        run_op("sra0",   SRA, 5'd0,  32'hDEADBEEF, 32'hDEADBEEF);
        run_op("srl0",   SRL, 5'd0,  32'hDEADBEEF, 32'hDEADBEEF);
        run_op("ror0",   ROR, 5'd0,  32'hDEADBEEF, 32'hDEADBEEF);

        // Restart two cycles into an operation: only the second one completes.
        do_start(SRA, 5'd8, 32'h12345678);
        @(posedge clock); #1;
        chk("abort busy", busy, 1'b1);
        do_start(SLL, 5'd3, 32'h00000001);
        wait_result("restart", 32'h00000008, last_result);
        @(posedge clock); #1;
        chk("restart rdy_off", data_resultRDY, 1'b0);
        chk("restart idle", busy, 1'b0);

        // Back-to-back: second start sampled at the end of the RDY cycle.
        do_start(SRL, 5'd4, 32'hF0000000);
        wait_result("b2b_a", 32'h0F000000, last_result);
        do_start(ROR, 5'd1, 32'h00000001);
        wait_result("b2b_b", 32'h80000000, last_result);
        @(posedge clock); #1;
        chk("b2b rdy_off", data_resultRDY, 1'b0);

        // Asynchronous reset three cycles into an operation.
        do_start(SLL, 5'd2, 32'h00000011);
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset_n = 1'b0;
        #1;
        chk("areset result", data_result, 32'h0);
        chk("areset rdy", data_resultRDY, 1'b0);
        chk("areset busy", busy, 1'b0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        last_result = 32'h0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clock); #1;
            chk("after reset rdy", data_resultRDY, 1'b0);
            chk("after reset busy", busy, 1'b0);
            chk("after reset result", data_result, 32'h0);
        end
        run_op("post_reset", SRL, 5'd31, 32'h80000000, 32'h00000001);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
